// File: rtl/flash_pkg.sv
// Shared types and constants for the LED flash sequencer: FSM encoding,
// pattern mode codes, initial patterns and the per-step pattern update.
package flash_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ModeToggle = 2'd0,
      ModeRotl   = 2'd1,
      ModeRotr   = 2'd2,
      ModePing   = 2'd3
   } mode_t;

   localparam logic [3:0] InitToggle = 4'b0000;
   localparam logic [3:0] InitRotl   = 4'b0001;
   localparam logic [3:0] InitRotr   = 4'b1000;
   localparam logic [3:0] InitPing   = 4'b0001;

   // Ping-pong turns around at these two end positions.
   localparam logic [3:0] PingLeftEnd  = 4'b1000;
   localparam logic [3:0] PingRightEnd = 4'b0001;

   typedef struct packed {
      logic [3:0] led;
      logic       dir_left;
   } step_t;

   function automatic logic [3:0] init_pattern(input mode_t mode);
      logic [3:0] pat;
      unique case (mode)
         ModeToggle: pat = InitToggle;
         ModeRotl:   pat = InitRotl;
         ModeRotr:   pat = InitRotr;
         ModePing:   pat = InitPing;
      endcase
      return pat;
   endfunction

   // Pattern (and ping-pong direction) after one step tick.
   function automatic step_t next_step(input mode_t mode, input logic [3:0] led,
                                       input logic dir_left);
      step_t s;
      s.led      = led;
      s.dir_left = dir_left;
      unique case (mode)
         ModeToggle: s.led = ~led;
         ModeRotl:   s.led = {led[2:0], led[3]};
         ModeRotr:   s.led = {led[0], led[3:1]};
         ModePing: begin
            if (dir_left) begin
               if (led == PingLeftEnd) begin
                  s.led      = {1'b0, led[3:1]};
                  s.dir_left = 1'b0;
               end else begin
                  s.led = {led[2:0], 1'b0};
               end
            end else begin
               if (led == PingRightEnd) begin
                  s.led      = {led[2:0], 1'b0};
                  s.dir_left = 1'b1;
               end else begin
                  s.led = {1'b0, led[3:1]};
               end
            end
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/flash_tick.sv
// Step-rate prescaler: counts 0..limit-1 while enabled and flags the last count.
module flash_tick #(
   parameter int unsigned NB_DIV = 26
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_enable,
   input  logic [NB_DIV-1:0] i_limit,
   output logic              o_tick
);

   logic [NB_DIV-1:0] count;
   logic              at_last;

   // Tick fires in the cycle the counter sits on its final value.
   always_comb begin
      at_last = (count == (i_limit - NB_DIV'(1)));
      o_tick  = i_enable && at_last;
   end

   // Prescaler counter; clear has priority over counting.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         count <= '0;
      end else if (i_clear) begin
         count <= '0;
      end else if (i_enable) begin
         if (at_last) begin
            count <= '0;
         end else begin
            count <= count + NB_DIV'(1);
         end
      end
   end

endmodule

// File: rtl/flash_sequencer.sv
// LED flash sequencer: runs one of four 4-bit patterns at a selectable step
// rate for a fixed number of steps (or continuously), with abort support.
module flash_sequencer
   import flash_pkg::*;
#(
   parameter int unsigned NB_DIV = 26,
   parameter int unsigned P_DIV0 = 50_000_000,
   parameter int unsigned P_DIV1 = 25_000_000,
   parameter int unsigned P_DIV2 = 12_500_000,
   parameter int unsigned P_DIV3 = 6_250_000
) (
   input  logic       clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic [1:0] i_mode,
   input  logic [1:0] i_period,
   input  logic [3:0] i_count,
   output logic [3:0] o_led,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [NB_DIV-1:0] Div0 = NB_DIV'(P_DIV0);
   localparam logic [NB_DIV-1:0] Div1 = NB_DIV'(P_DIV1);
   localparam logic [NB_DIV-1:0] Div2 = NB_DIV'(P_DIV2);
   localparam logic [NB_DIV-1:0] Div3 = NB_DIV'(P_DIV3);

   state_t            state, state_next;
   mode_t             run_mode;
   logic [1:0]        run_period;
   logic              continuous;
   logic [3:0]        steps, steps_next;
   logic              dir_left, dir_next;
   logic [3:0]        led_next;
   logic              busy_next, done_next;
   logic              load;
   logic              tick;
   logic [NB_DIV-1:0] limit;
   step_t             stepped;

   // Step limit follows the period latched at start, not the live input.
   always_comb begin
      unique case (run_period)
         2'd0: limit = Div0;
         2'd1: limit = Div1;
         2'd2: limit = Div2;
         2'd3: limit = Div3;
      endcase
   end

   flash_tick #(
      .NB_DIV (NB_DIV)
   ) u_tick (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_clear  (load),
      .i_enable (state == StRun),
      .i_limit  (limit),
      .o_tick   (tick)
   );

   // Next state, next registered outputs and step bookkeeping.
   always_comb begin
      state_next = state;
      led_next   = o_led;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      steps_next = steps;
      dir_next   = dir_left;
      load       = 1'b0;
      stepped    = next_step(run_mode, o_led, dir_left);
      unique case (state)
         StIdle: begin
            led_next = 4'b0000;
            // Stop overrides a simultaneous start.
            if (i_start && !i_stop) begin
               load       = 1'b1;
               state_next = StRun;
               led_next   = init_pattern(mode_t'(i_mode));
               busy_next  = 1'b1;
               steps_next = i_count;
               dir_next   = 1'b1;
            end
         end
         StRun: begin
            busy_next = 1'b1;
            if (i_stop) begin
               // Abort beats a coincident tick: no update, no done pulse.
               state_next = StIdle;
               led_next   = 4'b0000;
               busy_next  = 1'b0;
            end else if (tick) begin
               led_next = stepped.led;
               dir_next = stepped.dir_left;
               if (!continuous) begin
                  steps_next = steps - 4'd1;
                  if (steps == 4'd1) begin
                     state_next = StDone;
                     busy_next  = 1'b0;
                     done_next  = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            state_next = StIdle;
            led_next   = 4'b0000;
         end
         default: begin
            state_next = StIdle;
            led_next   = 4'b0000;
         end
      endcase
   end

   // FSM state, registered outputs and run counters.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state    <= StIdle;
         o_led    <= 4'b0000;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         steps    <= 4'd0;
         dir_left <= 1'b1;
      end else begin
         state    <= state_next;
         o_led    <= led_next;
         o_busy   <= busy_next;
         o_done   <= done_next;
         steps    <= steps_next;
         dir_left <= dir_next;
      end
   end

   // Run configuration, captured only when a run is accepted.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         run_mode   <= ModeToggle;
         run_period <= 2'd0;
         continuous <= 1'b0;
      end else if (load) begin
         run_mode   <= mode_t'(i_mode);
         run_period <= i_period;
         continuous <= (i_count == 4'd0);
      end
   end

endmodule
